// File: rtl/button_debounce.sv
// Two-channel push-button conditioner: 2-flop synchronizer, stable-count debounce,
// registered press/release pulses and a per-channel hold-to-repeat generator.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET,
  input  logic [1:0] KEY_N,
  output logic [1:0] BTN,
  output logic [1:0] BTN_PRESS,
  output logic [1:0] BTN_RELEASE,
  output logic [1:0] BTN_REPEAT
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]      RD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0]      RP_LAST = 24'(REPEAT_PERIOD - 1);
  localparam bit               RPT_EN  = (REPEAT_DELAY > 0);

  typedef enum logic {RPT_DELAY, RPT_PERIOD} rpt_state_t;

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] s;

  // Synchronizer stage: idle level is released (1), so reset drives 1
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= KEY_N;
      sync_p1 <= sync_p0;
    end
  end

  assign s = ~sync_p1;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             press_q;
    logic             rel_q;
    logic             rpt_q;
    logic             accept;
    rpt_state_t       state;
    logic [23:0]      rc;

    assign accept = (s[i] != btn_q) && (cnt == DB_LAST);

    // Debounce stage
    always_ff @(posedge CLK_25MHZ) begin
      if (RESET) begin
        cnt     <= '0;
        btn_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (s[i] == btn_q) begin
          cnt <= '0;
        end else if (accept) begin
          btn_q   <= s[i];
          cnt     <= '0;
          press_q <= s[i];
          rel_q   <= ~s[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Repeat stage: idle covers the press edge (btn_q still 0) and the release edge
    always_ff @(posedge CLK_25MHZ) begin
      if (RESET || !btn_q || accept || !RPT_EN) begin
        state <= RPT_DELAY;
        rc    <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        case (state)
          RPT_DELAY: begin
            if (rc == RD_LAST) begin
              rpt_q <= 1'b1;
              rc    <= '0;
              state <= RPT_PERIOD;
            end else begin
              rc <= rc + 24'd1;
            end
          end
          RPT_PERIOD: begin
            if (rc == RP_LAST) begin
              rpt_q <= 1'b1;
              rc    <= '0;
            end else begin
              rc <= rc + 24'd1;
            end
          end
          default: begin
            state <= RPT_DELAY;
            rc    <= '0;
          end
        endcase
      end
    end

    assign BTN[i]         = btn_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = rel_q;
    assign BTN_REPEAT[i]  = rpt_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n;
  logic [1:0] btn;
  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] rpt;
  logic [7:0] outs;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLK_25MHZ  (clk),
    .RESET      (rst),
    .KEY_N      (key_n),
    .BTN        (btn),
    .BTN_PRESS  (press),
    .BTN_RELEASE(rel),
    .BTN_REPEAT (rpt)
  );

  assign outs = {btn, press, rel, rpt};

  function automatic logic [7:0] exp_vec(input logic [1:0] b, input logic [1:0] p,
                                         input logic [1:0] r, input logic [1:0] t);
    return {b, p, r, t};
  endfunction

  function automatic logic [1:0] rep0(input int k);
    return (k >= 10 && (k - 10) % 3 == 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("reset_idle", outs, 8'h00);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_idle", outs, 8'h00);
    end

    // channel 0 press, hold with auto-repeat, release
    key_n = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("press0_wait", outs, 8'h00);
    end
    tick();
    check("press0", outs, exp_vec(2'b01, 2'b01, 2'b00, 2'b00));
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("repeat0", outs, exp_vec(2'b01, 2'b00, 2'b00, rep0(k)));
    end
    key_n = 2'b11;
    for (int k = 31; k <= 36; k++) begin
      tick();
      check("release0", outs, exp_vec((k == 36) ? 2'b00 : 2'b01, 2'b00,
                                      (k == 36) ? 2'b01 : 2'b00, rep0(k)));
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      check("after_release0", outs, 8'h00);
    end

    // channel 1 bounce never reaches the stable count
    for (int b = 0; b < 3; b++) begin
      key_n = 2'b01;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("bounce1_low", outs, 8'h00);
      end
      key_n = 2'b11;
      tick();
      check("bounce1_high", outs, 8'h00);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bounce1_settle", outs, 8'h00);
    end

    // both channels pressed and released together
    key_n = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("both_press_wait", outs, 8'h00);
    end
    tick();
    check("both_press", outs, exp_vec(2'b11, 2'b11, 2'b00, 2'b00));
    tick();
    check("both_held", outs, exp_vec(2'b11, 2'b00, 2'b00, 2'b00));
    key_n = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("both_release_wait", outs, exp_vec(2'b11, 2'b00, 2'b00, 2'b00));
    end
    tick();
    check("both_release", outs, exp_vec(2'b00, 2'b00, 2'b11, 2'b00));
    tick();
    check("both_idle", outs, 8'h00);

    // reset in the middle of a debounce count, key kept low
    key_n = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midcount", outs, 8'h00);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midcount_reset", outs, 8'h00);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("after_reset_wait", outs, 8'h00);
    end
    tick();
    check("after_reset_press", outs, exp_vec(2'b01, 2'b01, 2'b00, 2'b00));
    tick();
    check("after_reset_held", outs, exp_vec(2'b01, 2'b00, 2'b00, 2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, SHALL set the consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); legal range is 1 or more.
REQ-002 Parameter REPEAT_DELAY, default 12500000, SHALL set the cycles from the accepted press to the first repeat pulse (0.5 s); a value of 0 disables repeat.
REQ-003 Parameter REPEAT_PERIOD, default 2500000, SHALL set the cycles between later repeat pulses (0.1 s); legal range is 1 or more.
REQ-004 CLK_25MHZ  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-006 KEY_N  input  2  SHALL carry the raw asynchronous push-buttons, active-low (0 = pressed); bit 0 = up, bit 1 = down.
REQ-007 BTN  output  2  SHALL carry the debounced level per channel, active-high (1 = pressed).
REQ-008 BTN_PRESS  output  2  SHALL carry a one-cycle pulse per channel on each accepted press.
REQ-009 BTN_RELEASE  output  2  SHALL carry a one-cycle pulse per channel on each accepted release.
REQ-010 BTN_REPEAT  output  2  SHALL carry a one-cycle auto-repeat pulse per channel while the channel is held.

Function
REQ-011 Each KEY_N bit SHALL pass through a 2-flop synchronizer; the inverted second-flop output is the synchronized value s[i] (1 = pressed).
REQ-012 Channels SHALL be fully independent; simultaneous events on both channels SHALL each be handled in the same cycle.
REQ-013 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1) bits, with no wrap.
- s[i] == BTN[i]: counter cleared to 0.
- s[i] != BTN[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
REQ-014 If s[i] != BTN[i] and counter == DEBOUNCE_CYCLES-1, the next edge SHALL:
- set BTN[i] <= s[i] and clear the counter;
- assert BTN_PRESS[i] (rising) or BTN_RELEASE[i] (falling) for exactly that one cycle, coincident with the new BTN[i] value.
REQ-015 Latency from a clean KEY_N change (stable before edge 1) to the BTN change SHALL be 2 + DEBOUNCE_CYCLES edges.
REQ-016 Any single cycle of s[i] == BTN[i] during a count (bounce) SHALL restart the count from 0; a mismatch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
REQ-017 Repeat logic per channel: a 2-state FSM DELAY/PERIOD plus a 24-bit counter rc.
REQ-018 While BTN[i] == 0, or in the cycle BTN_PRESS[i] is asserted, the repeat logic SHALL hold state = DELAY and rc = 0.
REQ-019 While BTN[i] == 1 after the press cycle, rc SHALL increment each cycle; then:
- DELAY, rc == REPEAT_DELAY-1: pulse BTN_REPEAT[i], rc <= 0, go to PERIOD.
- PERIOD, rc == REPEAT_PERIOD-1: pulse BTN_REPEAT[i], rc <= 0, stay in PERIOD.
REQ-020 The first repeat pulse SHALL occur REPEAT_DELAY cycles after the BTN_PRESS pulse; later pulses SHALL occur every REPEAT_PERIOD cycles.
REQ-021 An accepted release SHALL force DELAY, rc = 0 on the same edge; BTN_REPEAT SHALL never coincide with BTN_RELEASE.
REQ-022 BTN_PRESS, BTN_RELEASE and BTN_REPEAT SHALL all be registered outputs.

Reset
REQ-023 While RESET = 1, the following SHALL hold:
- synchronizer flops = 1 (released);
- BTN = 0, all pulse outputs = 0;
- debounce counters = 0;
- repeat FSMs = DELAY, rc = 0.
REQ-024 Reset asserted mid-count or mid-hold SHALL abort all activity with no pulse emitted, including on the edge that reset is released.
REQ-025 A key held through reset SHALL be accepted as a fresh press 2 + DEBOUNCE_CYCLES edges after reset is released.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Reset with KEY_N=11 -> BTN=00, all pulse outputs 00, held for 20 cycles.
REQ-027 KEY_N[0] 1->0 and held -> BTN[0]=1 and a one-cycle BTN_PRESS[0] exactly 6 edges later; BTN[1] stays 0.
REQ-028 KEY_N[1] bounce (three 3-cycle lows separated by 1-cycle highs), then held high -> BTN[1] stays 0 with no pulses.
REQ-029 KEY_N[0] held low for 30 cycles past the press -> BTN_REPEAT[0] pulses at press+10, +13, +16, +19, ...; after release and 6 edges, BTN_RELEASE[0] pulses and repeats stop.
REQ-030 Both KEY_N bits fall on the same edge -> BTN_PRESS=11 in the same cycle; both rise on the same edge -> BTN_RELEASE=11 in the same cycle.
REQ-031 RESET pulsed at debounce count 2, with KEY_N[0] still low -> no pulse during or after reset; BTN_PRESS[0] fires 6 edges after reset is released.
